// File: rtl/mac8_sequencer.sv
// mac8_sequencer: shared operand-index / write-back controller for the
// 8-lane MAC matrix-multiply datapath. All lanes run in lockstep off the
// indices generated here; lane L owns output row L.
//
// Optional build feature: define MAC8_SEQ_STALL_CNT_EN to add the
// stall_count output (WAIT_BUF cycles plus DRAIN cycles with buf_busy=1).
module mac8_sequencer #(
  parameter int DIM     = 8,
  parameter int MAC_LAT = 2,
  parameter int AW      = 6,
  parameter int CW      = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic                     buf_busy,
  output logic                     busy,
  output logic                     done,
  output logic                     issue_valid,
  output logic [AW-1:0]            a_addr,
  output logic [$clog2(DIM)-1:0]   k_idx,
  output logic                     macc_clear,
  output logic                     wb_valid,
  output logic [$clog2(DIM)-1:0]   wb_col,
  output logic [CW-1:0]            cycle_count
`ifdef MAC8_SEQ_STALL_CNT_EN
  ,
  output logic [CW-1:0]            stall_count
`endif
);

  localparam int IW = $clog2(DIM);

  // DIM is a power of two, so the all-ones index is DIM-1.
  localparam logic [IW-1:0] IDX_ZERO = {IW{1'b0}};
  localparam logic [IW-1:0] IDX_ONE  = {{(IW-1){1'b0}}, 1'b1};
  localparam logic [IW-1:0] IDX_LAST = {IW{1'b1}};
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ISSUE    = 3'd1,
    ST_WAIT_BUF = 3'd2,
    ST_DRAIN    = 3'd3,
    ST_DONE     = 3'd4
  } state_t;

  state_t         state_r;
  logic [IW-1:0]  col_r;
  logic [IW-1:0]  k_r;

  // Write-back tag pipeline: stage 0 is loaded on the last-term issue
  // cycle, the final stage drives wb_valid/wb_col directly.
  logic [MAC_LAT-1:0] pipe_vld_r;
  logic [IW-1:0]      pipe_col_r [MAC_LAT];

  logic push_s;
  logic pending_s;

  // A address is col + DIM*k; with DIM a power of two that is {k, col}.
  function automatic logic [AW-1:0] operand_addr(input logic [IW-1:0] c,
                                                 input logic [IW-1:0] kk);
    logic [2*IW-1:0] full;
    full = {kk, c};
    return AW'(full);
  endfunction

  // Saturating increment for the cycle/stall counters.
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    logic [CW-1:0] r;
    if (v == CNT_MAX) begin
      r = v;
    end else begin
      r = v + CNT_ONE;
    end
    return r;
  endfunction

  // Last term of a column enters the write-back pipeline.
  always_comb begin
    push_s = 1'b0;
    if ((state_r == ST_ISSUE) && (k_r == IDX_LAST)) begin
      push_s = 1'b1;
    end else begin
      push_s = 1'b0;
    end
  end

  // Any write-back still queued behind the one currently on wb_valid.
  always_comb begin
    pending_s = 1'b0;
    for (int i = 0; i < MAC_LAT - 1; i++) begin
      pending_s = pending_s | pipe_vld_r[i];
    end
  end

  // Free-running write-back delay line; never stalled by buf_busy.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pipe_vld_r <= {MAC_LAT{1'b0}};
      for (int i = 0; i < MAC_LAT; i++) begin
        pipe_col_r[i] <= IDX_ZERO;
      end
    end else begin
      pipe_vld_r[0] <= push_s;
      pipe_col_r[0] <= col_r;
      for (int i = 1; i < MAC_LAT; i++) begin
        pipe_vld_r[i] <= pipe_vld_r[i-1];
        pipe_col_r[i] <= pipe_col_r[i-1];
      end
    end
  end

  assign wb_valid = pipe_vld_r[MAC_LAT-1];
  assign wb_col   = pipe_col_r[MAC_LAT-1];

  // Sequencer FSM; outputs are loaded with the values for the next cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= ST_IDLE;
      col_r       <= IDX_ZERO;
      k_r         <= IDX_ZERO;
      busy        <= 1'b0;
      done        <= 1'b0;
      issue_valid <= 1'b0;
      a_addr      <= {AW{1'b0}};
      k_idx       <= IDX_ZERO;
      macc_clear  <= 1'b0;
      cycle_count <= CNT_ZERO;
    end else begin
      case (state_r)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            state_r     <= ST_ISSUE;
            col_r       <= IDX_ZERO;
            k_r         <= IDX_ZERO;
            busy        <= 1'b1;
            issue_valid <= 1'b1;
            a_addr      <= operand_addr(IDX_ZERO, IDX_ZERO);
            k_idx       <= IDX_ZERO;
            macc_clear  <= 1'b1;
            cycle_count <= CNT_ZERO;
          end else begin
            // cycle_count keeps the last run's total while idle
            state_r     <= ST_IDLE;
            issue_valid <= 1'b0;
            macc_clear  <= 1'b0;
          end
        end

        ST_ISSUE: begin
          cycle_count <= sat_inc(cycle_count);
          if (k_r != IDX_LAST) begin
            k_r         <= k_r + IDX_ONE;
            issue_valid <= 1'b1;
            a_addr      <= operand_addr(col_r, k_r + IDX_ONE);
            k_idx       <= k_r + IDX_ONE;
            macc_clear  <= 1'b0;
          end else begin
            k_r <= IDX_ZERO;
            if (col_r == IDX_LAST) begin
              state_r     <= ST_DRAIN;
              issue_valid <= 1'b0;
              macc_clear  <= 1'b0;
            end else begin
              col_r <= col_r + IDX_ONE;
              if (buf_busy) begin
                // column boundary: hold off until the buffer is free
                state_r     <= ST_WAIT_BUF;
                issue_valid <= 1'b0;
                macc_clear  <= 1'b0;
              end else begin
                issue_valid <= 1'b1;
                a_addr      <= operand_addr(col_r + IDX_ONE, IDX_ZERO);
                k_idx       <= IDX_ZERO;
                macc_clear  <= 1'b1;
              end
            end
          end
        end

        ST_WAIT_BUF: begin
          cycle_count <= sat_inc(cycle_count);
          if (!buf_busy) begin
            state_r     <= ST_ISSUE;
            issue_valid <= 1'b1;
            a_addr      <= operand_addr(col_r, IDX_ZERO);
            k_idx       <= IDX_ZERO;
            macc_clear  <= 1'b1;
          end else begin
            state_r     <= ST_WAIT_BUF;
            issue_valid <= 1'b0;
            macc_clear  <= 1'b0;
          end
        end

        ST_DRAIN: begin
          cycle_count <= sat_inc(cycle_count);
          issue_valid <= 1'b0;
          macc_clear  <= 1'b0;
          // wb_valid in flight this cycle is the last one once nothing
          // is queued behind it
          if (!pending_s && !buf_busy) begin
            state_r <= ST_DONE;
            done    <= 1'b1;
          end else begin
            state_r <= ST_DRAIN;
            done    <= 1'b0;
          end
        end

        ST_DONE: begin
          cycle_count <= sat_inc(cycle_count);
          state_r     <= ST_IDLE;
          done        <= 1'b0;
          busy        <= 1'b0;
          issue_valid <= 1'b0;
          macc_clear  <= 1'b0;
        end

        default: begin
          state_r     <= ST_IDLE;
          col_r       <= IDX_ZERO;
          k_r         <= IDX_ZERO;
          busy        <= 1'b0;
          done        <= 1'b0;
          issue_valid <= 1'b0;
          macc_clear  <= 1'b0;
        end
      endcase
    end
  end

`ifdef MAC8_SEQ_STALL_CNT_EN
  // Back-pressure cycles: every WAIT_BUF cycle and blocked DRAIN cycles.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_count <= CNT_ZERO;
    end else if ((state_r == ST_IDLE) && start) begin
      stall_count <= CNT_ZERO;
    end else if ((state_r == ST_WAIT_BUF) ||
                 ((state_r == ST_DRAIN) && buf_busy)) begin
      stall_count <= sat_inc(stall_count);
    end else begin
      stall_count <= stall_count;
    end
  end
`else
  // stall counting not built; no extra state
`endif

endmodule

// File: tb/tb_mac8_sequencer.sv
// Self-checking bench for mac8_sequencer: random buf_busy patterns are
// turned into an expected per-cycle schedule by a column-level model.
module tb_mac8_sequencer;
  localparam int DIM     = 8;
  localparam int MAC_LAT = 2;
  localparam int AW      = 6;
  localparam int CW      = 16;
  localparam int CW2     = 6;
  localparam int IW      = 3;
  localparam int MAXC    = 512;
  localparam int BB_LIM  = 300;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic start = 1'b0;
  logic buf_busy = 1'b0;

  logic          busy, done, issue_valid, macc_clear, wb_valid;
  logic [AW-1:0] a_addr;
  logic [IW-1:0] k_idx, wb_col;
  logic [CW-1:0] cycle_count;

  logic          busy2, done2, issue_valid2, macc_clear2, wb_valid2;
  logic [AW-1:0] a_addr2;
  logic [IW-1:0] k_idx2, wb_col2;
  logic [CW2-1:0] cycle_count2;
`ifdef MAC8_SEQ_STALL_CNT_EN
  logic [CW-1:0]  stall_count;
  logic [CW2-1:0] stall_count2;
`endif

  mac8_sequencer #(.DIM(DIM), .MAC_LAT(MAC_LAT), .AW(AW), .CW(CW)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .buf_busy(buf_busy),
    .busy(busy), .done(done), .issue_valid(issue_valid), .a_addr(a_addr),
    .k_idx(k_idx), .macc_clear(macc_clear), .wb_valid(wb_valid),
    .wb_col(wb_col), .cycle_count(cycle_count)
`ifdef MAC8_SEQ_STALL_CNT_EN
    , .stall_count(stall_count)
`endif
  );

  // narrow cycle counter copy to exercise saturation
  mac8_sequencer #(.DIM(DIM), .MAC_LAT(MAC_LAT), .AW(AW), .CW(CW2)) dut_cw6 (
    .clk(clk), .reset_n(reset_n), .start(start), .buf_busy(buf_busy),
    .busy(busy2), .done(done2), .issue_valid(issue_valid2), .a_addr(a_addr2),
    .k_idx(k_idx2), .macc_clear(macc_clear2), .wb_valid(wb_valid2),
    .wb_col(wb_col2), .cycle_count(cycle_count2)
`ifdef MAC8_SEQ_STALL_CNT_EN
    , .stall_count(stall_count2)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // expected schedule, indexed by cycle relative to the start sample
  bit bb     [MAXC];
  bit e_iv   [MAXC];
  int e_addr [MAXC];
  int e_k    [MAXC];
  bit e_wb   [MAXC];
  int e_wbcol[MAXC];
  int e_done;
  int e_stall;

  task automatic check_val(input string tag, input logic [31:0] obs,
                           input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Column-by-column schedule: 8 issues per column, optional buffer wait
  // at each column boundary, write-back MAC_LAT after each last term,
  // then drain until write-backs are out and the buffer is free.
  task automatic build_model();
    int t, tl, e;
    for (int i = 0; i < MAXC; i++) begin
      e_iv[i] = 1'b0; e_addr[i] = 0; e_k[i] = 0; e_wb[i] = 1'b0; e_wbcol[i] = 0;
    end
    t = 1; tl = 0; e_stall = 0;
    for (int c = 0; c < DIM; c++) begin
      for (int k = 0; k < DIM; k++) begin
        e_iv[t] = 1'b1;
        e_addr[t] = (c + DIM * k) % (1 << AW);
        e_k[t] = k;
        t++;
      end
      tl = t - 1;
      e_wb[tl + MAC_LAT] = 1'b1;
      e_wbcol[tl + MAC_LAT] = c;
      if (c < DIM - 1 && bb[tl]) begin
        e = tl + 1;
        while (bb[e]) e++;
        e_stall += e - tl;
        t = e + 1;
      end
    end
    e = tl + 1;
    while (e < tl + MAC_LAT || bb[e]) begin
      if (bb[e]) e_stall++;
      e++;
    end
    e_done = e + 1;
  endtask

  task automatic clear_bb();
    for (int i = 0; i < MAXC; i++) bb[i] = 1'b0;
  endtask

  task automatic abort_run();
    reset_n = 1'b0;
    #1;
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_issue", 32'(issue_valid), 32'd0);
    check_val("rst_addr", 32'(a_addr), 32'd0);
    check_val("rst_kidx", 32'(k_idx), 32'd0);
    check_val("rst_clear", 32'(macc_clear), 32'd0);
    check_val("rst_wb", 32'(wb_valid), 32'd0);
    check_val("rst_wbcol", 32'(wb_col), 32'd0);
    check_val("rst_done", 32'(done), 32'd0);
    check_val("rst_ccount", 32'(cycle_count), 32'd0);
    start = 1'b0;
    buf_busy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    for (int n = 0; n < 20; n++) begin
      @(posedge clk); #1;
      check_val("post_rst_wb", 32'(wb_valid), 32'd0);
      check_val("post_rst_done", 32'(done), 32'd0);
      check_val("post_rst_busy", 32'(busy), 32'd0);
    end
  endtask

  // Called #1 after a clock edge with the DUT idle; current cycle is 0.
  task automatic run_seq(input bit hold_start, input int abort_at);
    build_model();
    start = 1'b1;
    buf_busy = bb[0];
    for (int n = 1; n <= e_done + 2; n++) begin
      @(posedge clk); #1;
      if (n == abort_at) begin
        abort_run();
        return;
      end
      check_val("issue_valid", 32'(issue_valid), 32'(e_iv[n]));
      if (e_iv[n]) begin
        check_val("a_addr", 32'(a_addr), e_addr[n]);
        check_val("k_idx", 32'(k_idx), e_k[n]);
      end
      check_val("macc_clear", 32'(macc_clear), 32'(e_iv[n] && e_k[n] == 0));
      check_val("wb_valid", 32'(wb_valid), 32'(e_wb[n]));
      if (e_wb[n]) check_val("wb_col", 32'(wb_col), e_wbcol[n]);
      check_val("done", 32'(done), 32'(n == e_done));
      check_val("busy", 32'(busy), 32'(n <= e_done));
      check_val("done_cw6", 32'(done2), 32'(n == e_done));
      if (n == e_done + 1) begin
        check_val("cycle_count", 32'(cycle_count),
                  (e_done > 65535) ? 65535 : e_done);
        check_val("cycle_count_sat", 32'(cycle_count2),
                  (e_done > 63) ? 63 : e_done);
`ifdef MAC8_SEQ_STALL_CNT_EN
        check_val("stall_count", 32'(stall_count), e_stall);
`endif
      end
      start = hold_start && (n <= e_done);
      buf_busy = bb[n];
    end
    start = 1'b0;
    buf_busy = 1'b0;
  endtask

  initial begin
    #1;
    check_val("init_busy", 32'(busy), 32'd0);
    check_val("init_issue", 32'(issue_valid), 32'd0);
    check_val("init_wb", 32'(wb_valid), 32'd0);
    check_val("init_done", 32'(done), 32'd0);
    check_val("init_ccount", 32'(cycle_count), 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_val("idle_busy", 32'(busy), 32'd0);

    // no back-pressure
    clear_bb();
    run_seq(1'b0, 0);

    // buffer busy across the first column boundary
    clear_bb();
    for (int i = 8; i <= 12; i++) bb[i] = 1'b1;
    run_seq(1'b0, 0);

    // buffer busy through the drain
    clear_bb();
    for (int i = 60; i <= 70; i++) bb[i] = 1'b1;
    run_seq(1'b0, 0);

    // start held high for the whole run
    clear_bb();
    for (int i = 0; i < BB_LIM; i++) bb[i] = ($urandom_range(0, 4) == 0);
    run_seq(1'b1, 0);

    // reset in the middle of a run, then a clean run
    clear_bb();
    run_seq(1'b0, 30);
    clear_bb();
    run_seq(1'b0, 0);

    // random back-pressure
    for (int r = 0; r < 6; r++) begin
      clear_bb();
      for (int i = 0; i < BB_LIM; i++) bb[i] = ($urandom_range(0, 2) == 0);
      run_seq(1'b0, 0);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
